// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Receives a byte-serial program image and writes it word by word into the
// instruction memory write port, holding the core in reset until the image
// has been completely written.
//
// Image format: N[7:0], N[15:8], then N little-endian 32-bit words.
// Optional build macro IMEM_LOADER_CHKSUM_EN appends one checksum byte
// (modulo-256 sum of all payload bytes) that must match before DONE.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   rx_data     incoming image byte
//   rx_valid    rx_data valid
//   rx_ready    loader can accept a byte
//   start       one-cycle pulse, restarts a load from DONE or ERR
//   imem_we     instruction memory write strobe, one cycle per word
//   imem_waddr  word address of the write
//   imem_wdata  assembled instruction word
//   core_hold   1 = keep the core's PC/regs in reset
//   done        image fully written
//   error       image rejected
//   word_count  words written in the current load
//   fsm_state   debug view of the FSM state register
//
// Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
// are both 1. rx_ready depends only on registered state, never on rx_valid;
// rx_valid while rx_ready=0 has no effect.
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count,
    output logic [2:0]        fsm_state
);

    localparam logic [2:0] S_HDR0 = 3'd0;
    localparam logic [2:0] S_HDR1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;
`ifdef IMEM_LOADER_CHKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd5;
    // State entered once all payload words are written.
    localparam logic [2:0] S_END  = S_CHK;
`else
    localparam logic [2:0] S_END  = S_DONE;
`endif

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    logic [2:0]  state;
    logic        live;        // 0 during reset and its first cycle out
    logic [1:0]  lane;
    logic [15:0] len;
    logic [23:0] asm_q;       // first three bytes of the word in flight
    logic        last_pulse;
    logic        accept;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]  sum;
`endif

    // The final write pulse is the cycle in which word_count reaches N; no
    // further byte may be taken then, since the image is complete.
    assign last_pulse = imem_we && (word_count == len);
    assign accept     = rx_valid && rx_ready;

    always_comb begin
        rx_ready = 1'b0;
        case (state)
            S_HDR0, S_HDR1: rx_ready = live;
            S_DATA:         rx_ready = live && !last_pulse;
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK:          rx_ready = live;
`endif
            default:        rx_ready = 1'b0;
        endcase
    end

    assign core_hold = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_HDR0;
            live       <= 1'b0;
            lane       <= 2'd0;
            len        <= 16'd0;
            asm_q      <= 24'd0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 32'd0;
            word_count <= 16'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            live    <= 1'b1;
            imem_we <= 1'b0;
            // Address follows the word index: step once a write has gone out.
            if (imem_we) begin
                imem_waddr <= imem_waddr + ADDR_W'(1);
            end
            case (state)
                S_HDR0: begin
                    if (accept) begin
                        len[7:0] <= rx_data;
                        state    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        len[15:8] <= rx_data;
                        if ({1'b0, rx_data, len[7:0]} > DEPTH) begin
                            state <= S_ERR;
                        end else if ({rx_data, len[7:0]} == 16'd0) begin
                            state <= S_END;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        asm_q <= {rx_data, asm_q[23:8]};
                        lane  <= lane + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                        sum   <= sum + rx_data;
`endif
                        if (lane == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_data, asm_q};
                            imem_waddr <= word_count[ADDR_W-1:0];
                            word_count <= word_count + 16'd1;
                        end
                    end else if (last_pulse) begin
                        state <= S_END;
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        state <= (rx_data == sum) ? S_DONE : S_ERR;
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_HDR0;
                        lane       <= 2'd0;
                        len        <= 16'd0;
                        imem_waddr <= '0;
                        word_count <= 16'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
                        sum        <= 8'd0;
`endif
                    end
                end
                default: state <= S_HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed testbench for imem_loader (ADDR_W=8). Image bytes are driven
// through the valid/ready port; every imem_we pulse is matched against an
// expected queue of {addr, data} entries. Build with IMEM_LOADER_CHKSUM_EN
// defined to exercise the checksum byte.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int ST_HDR0 = 0;
    localparam int ST_DATA = 2;
    localparam int ST_ERR  = 4;
`ifdef IMEM_LOADER_CHKSUM_EN
    localparam int ST_CHK  = 5;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;
    logic [15:0]       word_count;
    logic [2:0]        fsm_state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [39:0] exp_q[$];
    logic [39:0] exp_e;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Write-port scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("we_addr", 64'(imem_waddr), 64'(exp_e[39:32]));
                check("we_data", 64'(imem_wdata), 64'(exp_e[31:0]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte, hold it until accepted, return 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("rx_ready_wait", 64'(rx_ready), 1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_done", 64'(done), 0);
        check("start_err", 64'(error), 0);
        check("start_hold", 64'(core_hold), 1);
        check("start_wc", 64'(word_count), 0);
        check("start_waddr", 64'(imem_waddr), 0);
        check("start_ready", 64'(rx_ready), 1);
    endtask

    // Called in the cycle of the final write pulse.
    task automatic end_image(input logic [7:0] sum);
        check("last_we", 64'(imem_we), 1);
        check("last_ready", 64'(rx_ready), 0);
        check("last_done", 64'(done), 0);
        tick();
`ifdef IMEM_LOADER_CHKSUM_EN
        check("chk_state", 64'(fsm_state), ST_CHK);
        check("chk_done", 64'(done), 0);
        send_byte(sum);
`else
        check("sum_unused", 64'(sum), 64'(sum));
`endif
        check("end_done", 64'(done), 1);
        check("end_hold", 64'(core_hold), 0);
        check("end_we", 64'(imem_we), 0);
        check("end_ready", 64'(rx_ready), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_ready", 64'(rx_ready), 0);
        check("rst_we", 64'(imem_we), 0);
        check("rst_waddr", 64'(imem_waddr), 0);
        check("rst_wdata", 64'(imem_wdata), 0);
        check("rst_hold", 64'(core_hold), 1);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(error), 0);
        check("rst_wc", 64'(word_count), 0);
        check("rst_state", 64'(fsm_state), ST_HDR0);
        reset = 1'b1;
        #1;
        check("rel_ready_low", 64'(rx_ready), 0);
        tick();
        check("rel_ready_high", 64'(rx_ready), 1);

        // Two-word image, back-to-back bytes
        exp_q.push_back({8'd0, 32'h00100513});
        exp_q.push_back({8'd1, 32'h00200593});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
        check("t1_wc", 64'(word_count), 2);
        check("t1_waddr", 64'(imem_waddr), 1);
        end_image(8'hE0);
        check("t1_writes", 64'(wr_cnt), 2);

        // Restart; rx_valid toggling every cycle
        pulse_start();
        exp_q.push_back({8'd0, 32'hDEADBEEF});
        send_byte(8'h01); tick(); send_byte(8'h00); tick();
        send_byte(8'hEF); tick(); send_byte(8'hBE); tick();
        send_byte(8'hAD); tick(); send_byte(8'hDE);
        end_image(8'h38);
        // Bytes offered in DONE are refused
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_ready", 64'(rx_ready), 0);
        end
        rx_valid = 1'b0;
        tick();
        check("t2_writes", 64'(wr_cnt), 3);
        check("t2_wc", 64'(word_count), 1);

        // Oversized header N=0x0101 > 256
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        check("big_err", 64'(error), 1);
        check("big_hold", 64'(core_hold), 1);
        check("big_ready", 64'(rx_ready), 0);
        check("big_done", 64'(done), 0);
        tick();
        check("big_writes", 64'(wr_cnt), 3);
        pulse_start();
        check("big_state", 64'(fsm_state), ST_HDR0);

        // N=0x0100 equals DEPTH and is accepted
        send_byte(8'h00); send_byte(8'h01);
        check("depth_err", 64'(error), 0);
        check("depth_state", 64'(fsm_state), ST_DATA);
        reset = 1'b0;
        #1;
        check("depth_rst_state", 64'(fsm_state), ST_HDR0);
        tick();
        reset = 1'b1;
        tick();

        // Reset asserted after 6 payload bytes of a 3-word load
        exp_q.push_back({8'd0, 32'hA4A3A2A1});
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        send_byte(8'hB1); send_byte(8'hB2);
        check("mid_wc", 64'(word_count), 1);
        reset = 1'b0;
        #1;
        check("mid_ready", 64'(rx_ready), 0);
        check("mid_we", 64'(imem_we), 0);
        check("mid_waddr", 64'(imem_waddr), 0);
        check("mid_wdata", 64'(imem_wdata), 0);
        check("mid_hold", 64'(core_hold), 1);
        check("mid_done", 64'(done), 0);
        check("mid_err", 64'(error), 0);
        check("mid_wc0", 64'(word_count), 0);
        check("mid_state", 64'(fsm_state), ST_HDR0);
        tick();
        reset = 1'b1;
        tick();
        exp_q.push_back({8'd0, 32'h44332211});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        end_image(8'hAA);
        check("reload_writes", 64'(wr_cnt), 5);

        // Empty image N=0
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHKSUM_EN
        check("n0_chk_state", 64'(fsm_state), ST_CHK);
        check("n0_chk_ready", 64'(rx_ready), 1);
        send_byte(8'h00);
        check("n0_sum_done", 64'(done), 1);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("n0_bad_err", 64'(error), 1);
        check("n0_bad_done", 64'(done), 0);
`else
        check("n0_done", 64'(done), 1);
        check("n0_hold", 64'(core_hold), 0);
`endif
        tick();
        check("n0_writes", 64'(wr_cnt), 5);

`ifdef IMEM_LOADER_CHKSUM_EN
        // Checksum match then mismatch
        pulse_start();
        exp_q.push_back({8'd0, 32'h04030201});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        end_image(8'h0A);
        pulse_start();
        exp_q.push_back({8'd0, 32'h04030201});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick();
        check("bad_chk_state", 64'(fsm_state), ST_CHK);
        send_byte(8'h0B);
        check("bad_chk_err", 64'(error), 1);
        check("bad_chk_hold", 64'(core_hold), 1);
        check("bad_chk_state2", 64'(fsm_state), ST_ERR);
        tick();
        check("chk_writes", 64'(wr_cnt), 7);
`endif

        repeat (3) tick();
        check("exp_q_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
